// File: rtl/tdd_seq_gen_pkg.sv
// Shared types for the TDD sequence generator.
package tdd_seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

endpackage

// File: rtl/tdd_seq_gen_channel.sv
// One output channel: WINDOW_COUNT on/off window trackers plus the output register.
module tdd_seq_gen_channel #(
  parameter int unsigned WINDOW_COUNT   = 4,
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter logic        DEFAULT_LEVEL  = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               run_ok,
  input  logic [REGISTER_WIDTH-1:0]          counter,
  input  logic [WINDOW_COUNT-1:0]            win_en,
  input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] win_on,
  input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] win_off,
  input  logic                               ch_en,
  input  logic                               pol_run,
  input  logic                               pol_live,
  input  logic                               hold_idle,
  output logic                               tdd_out
);

  logic [WINDOW_COUNT-1:0] active;
  logic [WINDOW_COUNT-1:0] active_n;
  logic                    any_n;

  // Next window state: set after an on match, cleared after an off match (off wins),
  // and dropped whenever the frame is not continuing.
  always_comb begin
    active_n = '0;
    for (int unsigned w = 0; w < WINDOW_COUNT; w++) begin
      active_n[w] = run_ok && win_en[w] &&
        (((counter == win_on[w*REGISTER_WIDTH +: REGISTER_WIDTH]) &&
          (win_on[w*REGISTER_WIDTH +: REGISTER_WIDTH] != win_off[w*REGISTER_WIDTH +: REGISTER_WIDTH])) ||
         (active[w] && (counter != win_off[w*REGISTER_WIDTH +: REGISTER_WIDTH])));
    end
    any_n = |active_n;
  end

  // Window trackers and the output register; output follows the next window state
  // so the counter match reaches tdd_out one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= '0;
      tdd_out <= DEFAULT_LEVEL;
    end else begin
      active  <= active_n;
      tdd_out <= hold_idle ? pol_live : (pol_run ^ (ch_en & any_n));
    end
  end

endmodule

// File: rtl/tdd_seq_gen.sv
// TDD sequence generator: triggered bursts of frames with per-channel on/off windows.
module tdd_seq_gen
  import tdd_seq_gen_pkg::*;
#(
  parameter int unsigned                CHANNEL_COUNT     = 8,
  parameter int unsigned                WINDOW_COUNT      = 4,
  parameter int unsigned                REGISTER_WIDTH    = 32,
  parameter int unsigned                BURST_COUNT_WIDTH = 32,
  parameter logic [CHANNEL_COUNT-1:0]   DEFAULT_POLARITY  = '0
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic                                            sync,
  input  logic                                            sync_rst,
  input  logic [BURST_COUNT_WIDTH-1:0]                    burst_count,
  input  logic [REGISTER_WIDTH-1:0]                       startup_delay,
  input  logic [REGISTER_WIDTH-1:0]                       frame_length,
  input  logic [CHANNEL_COUNT-1:0]                        ch_en,
  input  logic [CHANNEL_COUNT-1:0]                        ch_pol,
  input  logic [CHANNEL_COUNT*WINDOW_COUNT-1:0]           win_en,
  input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] win_on,
  input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] win_off,
  output logic [CHANNEL_COUNT-1:0]                        tdd_out,
  output logic [1:0]                                      cstate,
  output logic [REGISTER_WIDTH-1:0]                       counter,
  output logic [BURST_COUNT_WIDTH-1:0]                    frame_index,
  output logic                                            end_of_frame,
  output logic                                            cfg_err
);

  localparam int unsigned WR = WINDOW_COUNT * REGISTER_WIDTH;

  state_t                          state, state_n;
  logic [REGISTER_WIDTH-1:0]       counter_n;
  logic [BURST_COUNT_WIDTH-1:0]    frame_index_n;
  logic                            cfg_err_n;
  logic                            trig, fl_ok, capture, run_ok, hold_idle;
  logic                            last_cycle;

  logic [BURST_COUNT_WIDTH-1:0]         burst_s;
  logic [REGISTER_WIDTH-1:0]            delay_s, flen_s;
  logic [CHANNEL_COUNT-1:0]             pol_s, pol_run;
  logic [CHANNEL_COUNT*WINDOW_COUNT-1:0] wen_s;
  logic [CHANNEL_COUNT*WR-1:0]          on_s, off_s;

  assign cstate       = state;
  assign last_cycle   = (counter == flen_s - 1'b1);
  assign end_of_frame = (state == RUNNING) && last_cycle;

  // Next-state, counter, frame index and error flag.
  always_comb begin
    state_n       = state;
    counter_n     = counter;
    frame_index_n = frame_index;
    cfg_err_n     = cfg_err;
    run_ok        = 1'b0;
    fl_ok         = (frame_length >= REGISTER_WIDTH'(2));
    trig          = sync && ((state == ARMED) ||
                             (sync_rst && ((state == WAITING) || (state == RUNNING))));
    capture       = enable && trig && fl_ok;
    if (!enable) begin
      state_n       = IDLE;
      counter_n     = '0;
      frame_index_n = '0;
      cfg_err_n     = 1'b0;
    end else if (capture) begin
      state_n       = (startup_delay != '0) ? WAITING : RUNNING;
      counter_n     = '0;
      frame_index_n = '0;
    end else begin
      // A rejected trigger flags the error but leaves the sequence untouched.
      if (trig) cfg_err_n = 1'b1;
      unique case (state)
        IDLE:    state_n = ARMED;
        ARMED:   ;
        WAITING: begin
          if (counter == delay_s - 1'b1) begin
            state_n   = RUNNING;
            counter_n = '0;
          end else begin
            counter_n = counter + 1'b1;
          end
        end
        RUNNING: begin
          if (last_cycle) begin
            counter_n = '0;
            if ((burst_s != '0) && (frame_index == burst_s - 1'b1)) begin
              state_n       = ARMED;
              frame_index_n = '0;
            end else begin
              frame_index_n = frame_index + 1'b1;
            end
          end else begin
            counter_n = counter + 1'b1;
            run_ok    = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    hold_idle = (state_n == IDLE) || (state_n == ARMED);
    pol_run   = capture ? ch_pol : pol_s;
  end

  // State register and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      frame_index <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      counter     <= counter_n;
      frame_index <= frame_index_n;
      cfg_err     <= cfg_err_n;
    end
  end

  // Shadow copy of the burst configuration, loaded on an accepted trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_s <= '0;
      delay_s <= '0;
      flen_s  <= '0;
      pol_s   <= '0;
      wen_s   <= '0;
      on_s    <= '0;
      off_s   <= '0;
    end else if (capture) begin
      burst_s <= burst_count;
      delay_s <= startup_delay;
      flen_s  <= frame_length;
      pol_s   <= ch_pol;
      wen_s   <= win_en;
      on_s    <= win_on;
      off_s   <= win_off;
    end
  end

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
    tdd_seq_gen_channel #(
      .WINDOW_COUNT   (WINDOW_COUNT),
      .REGISTER_WIDTH (REGISTER_WIDTH),
      .DEFAULT_LEVEL  (DEFAULT_POLARITY[c])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .run_ok    (run_ok),
      .counter   (counter),
      .win_en    (wen_s[c*WINDOW_COUNT +: WINDOW_COUNT]),
      .win_on    (on_s[c*WR +: WR]),
      .win_off   (off_s[c*WR +: WR]),
      .ch_en     (ch_en[c]),
      .pol_run   (pol_run[c]),
      .pol_live  (ch_pol[c]),
      .hold_idle (hold_idle),
      .tdd_out   (tdd_out[c])
    );
  end

endmodule

// File: tb/tb_tdd_seq_gen.sv
// Scoreboard bench for tdd_seq_gen: driver + reference model push expectations, monitor pops and compares.
module tb_tdd_seq_gen;

  localparam int C = 3;
  localparam int W = 2;
  localparam int R = 8;
  localparam int B = 4;
  localparam logic [C-1:0] DEF = 3'b101;

  logic               clk = 1'b0;
  logic               reset, enable, sync, sync_rst;
  logic [B-1:0]       burst_count;
  logic [R-1:0]       startup_delay, frame_length;
  logic [C-1:0]       ch_en, ch_pol;
  logic [C*W-1:0]     win_en;
  logic [C*W*R-1:0]   win_on, win_off;
  logic [C-1:0]       tdd_out;
  logic [1:0]         cstate;
  logic [R-1:0]       counter;
  logic [B-1:0]       frame_index;
  logic               end_of_frame, cfg_err;

  always #5 clk = ~clk;

  tdd_seq_gen #(
    .CHANNEL_COUNT     (C),
    .WINDOW_COUNT      (W),
    .REGISTER_WIDTH    (R),
    .BURST_COUNT_WIDTH (B),
    .DEFAULT_POLARITY  (DEF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .sync_rst(sync_rst),
    .burst_count(burst_count), .startup_delay(startup_delay), .frame_length(frame_length),
    .ch_en(ch_en), .ch_pol(ch_pol), .win_en(win_en), .win_on(win_on), .win_off(win_off),
    .tdd_out(tdd_out), .cstate(cstate), .counter(counter), .frame_index(frame_index),
    .end_of_frame(end_of_frame), .cfg_err(cfg_err)
  );

  typedef struct {
    logic [1:0]   st;
    logic [R-1:0] cnt;
    logic [B-1:0] fi;
    logic         eof;
    logic         err;
    logic [C-1:0] out;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  // Reference model: phase 0 idle, 1 armed, 2 startup delay, 3 in frame.
  int             m_st = 0, m_cnt = 0, m_fi = 0;
  bit             m_err = 0;
  int             s_bc = 0, s_sd = 0, s_fl = 0;
  logic [C-1:0]   s_pol = '0;
  logic [C*W-1:0] s_wen = '0;
  logic [C*W*R-1:0] s_on = '0, s_off = '0;

  // Is a window lit while the frame position is k?
  function automatic bit win_lit(int on, int off, int k);
    if (on == off) return 0;
    if (k <= on)   return 0;
    if (on < off)  return (k <= off);
    return 1;
  endfunction

  task automatic model_step(output exp_t e);
    bit trig;
    bit any;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_fi = 0; m_err = 0;
      s_bc = 0; s_sd = 0; s_fl = 0; s_pol = '0; s_wen = '0; s_on = '0; s_off = '0;
    end else if (!enable) begin
      m_st = 0; m_cnt = 0; m_fi = 0; m_err = 0;
    end else begin
      trig = sync && (m_st == 1 || (m_st >= 2 && sync_rst));
      if (trig && frame_length >= 2) begin
        s_bc = int'(burst_count); s_sd = int'(startup_delay); s_fl = int'(frame_length);
        s_pol = ch_pol; s_wen = win_en; s_on = win_on; s_off = win_off;
        m_st = (s_sd != 0) ? 2 : 3; m_cnt = 0; m_fi = 0;
      end else begin
        if (trig) m_err = 1;
        case (m_st)
          0: m_st = 1;
          2: if (m_cnt == s_sd - 1) begin m_st = 3; m_cnt = 0; end else m_cnt++;
          3: begin
            if (m_cnt == s_fl - 1) begin
              m_cnt = 0;
              if (s_bc != 0 && m_fi == s_bc - 1) begin m_st = 1; m_fi = 0; end
              else m_fi = (m_fi + 1) % (1 << B);
            end else m_cnt++;
          end
          default: ;
        endcase
      end
    end
    e.st  = 2'(m_st);
    e.cnt = R'(m_cnt);
    e.fi  = B'(m_fi);
    e.eof = (m_st == 3) && (m_cnt == s_fl - 1);
    e.err = m_err;
    for (int c = 0; c < C; c++) begin
      if (reset) e.out[c] = DEF[c];
      else if (m_st < 2) e.out[c] = ch_pol[c];
      else begin
        any = 0;
        if (m_st == 3)
          for (int w = 0; w < W; w++)
            if (s_wen[c*W+w] &&
                win_lit(int'(s_on[(c*W+w)*R +: R]), int'(s_off[(c*W+w)*R +: R]), m_cnt))
              any = 1;
        e.out[c] = s_pol[c] ^ (ch_en[c] & any);
      end
    end
  endtask

  // Model the coming edge with the inputs now applied, queue the expectation, advance.
  task automatic tick();
    exp_t e;
    model_step(e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_win(input int c, input int w, input bit en, input int on, input int off);
    win_en[c*W+w]           = en;
    win_on[(c*W+w)*R +: R]  = R'(on);
    win_off[(c*W+w)*R +: R] = R'(off);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    reset = 1; enable = 0; sync = 0; sync_rst = 0;
    burst_count = '0; startup_delay = '0; frame_length = '0;
    ch_en = '0; ch_pol = '0; win_en = '0; win_on = '0; win_off = '0;
    tick(); tick();
    reset = 0;
    // single burst: 2 frames of 10, delay 3, ch0 window 2..5
    burst_count = 2; startup_delay = 3; frame_length = 10; ch_en = '1;
    set_win(0, 0, 1, 2, 5);
    tick();
    enable = 1; tick();
    sync = 1; tick(); sync = 0;
    frame_length = 20;
    repeat (30) tick();
    // two windows with inverted polarity, plus an on==off window that never lights
    frame_length = 10; startup_delay = 0; burst_count = 0; ch_pol = 3'b011;
    set_win(0, 1, 1, 6, 8); set_win(0, 0, 1, 2, 4); set_win(1, 0, 1, 4, 4);
    sync = 1; tick(); sync = 0;
    repeat (16) tick();
    // retrigger with and without sync_rst
    sync = 1; sync_rst = 0; tick(); sync = 0; repeat (3) tick();
    startup_delay = 2;
    sync = 1; sync_rst = 1; tick(); sync = 0; sync_rst = 0; repeat (12) tick();
    // reset mid-run in infinite mode
    reset = 1; tick(); reset = 0; repeat (2) tick();
    // bad frame length and abort mid-window
    frame_length = 1; sync = 1; tick(); sync = 0; tick();
    frame_length = 10; sync = 1; tick(); sync = 0; repeat (6) tick();
    enable = 0; tick(); enable = 1; repeat (3) tick();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      enable   = ($urandom_range(0, 199) != 0);
      sync     = ($urandom_range(0, 19) == 0);
      sync_rst = $urandom_range(0, 1);
      ch_en    = ($urandom_range(0, 9) == 0) ? C'($urandom) : ch_en;
      if ($urandom_range(0, 14) == 0) begin
        burst_count   = B'($urandom_range(0, 3));
        startup_delay = R'($urandom_range(0, 4));
        frame_length  = ($urandom_range(0, 7) == 0) ? R'($urandom_range(0, 1))
                                                    : R'($urandom_range(2, 12));
        ch_pol        = C'($urandom);
        for (int c = 0; c < C; c++)
          for (int w = 0; w < W; w++)
            set_win(c, w, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 13), $urandom_range(0, 13));
      end
      tick();
    end
    done = 1;
  end

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    bit finished = 0;
    for (int i = 0; i < 10000 && !finished; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (done) finished = 1;
        else begin
          total++; bad++;
          $display("FAIL queue: got empty expected entry at %0t", $time);
        end
      end else begin
        e = q.pop_front();
        check("cstate",       32'(cstate),       32'(e.st));
        check("counter",      32'(counter),      32'(e.cnt));
        check("frame_index",  32'(frame_index),  32'(e.fi));
        check("end_of_frame", 32'(end_of_frame), 32'(e.eof));
        check("cfg_err",      32'(cfg_err),      32'(e.err));
        check("tdd_out",      32'(tdd_out),      32'(e.out));
      end
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL timeout: got running expected finished at %0t", $time);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdd_seq_gen.md
TDD_SEQ_GEN -- requirements
Module: tdd_seq_gen

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 8: number of output channels (1..32).
REQ-002 SHALL have parameter WINDOW_COUNT, default 4: on/off windows per channel (1..8).
REQ-003 SHALL have parameter REGISTER_WIDTH, default 32: width of timing values and counter.
REQ-004 SHALL have parameter BURST_COUNT_WIDTH, default 32: width of frame-repeat count.
REQ-005 SHALL have parameter DEFAULT_POLARITY, default 0 (CHANNEL_COUNT bits): idle level per channel in reset.
REQ-006 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: enable  in  1  engine enable; sync  in  1  trigger pulse, clk domain; sync_rst  in  1  allow retrigger while running.
REQ-008 SHALL have ports: burst_count  in  BURST_COUNT_WIDTH  frames per burst, 0 = infinite; startup_delay  in  REGISTER_WIDTH  cycles before first frame; frame_length  in  REGISTER_WIDTH  cycles per frame.
REQ-009 SHALL have ports: ch_en  in  CHANNEL_COUNT  channel enable; ch_pol  in  CHANNEL_COUNT  output inversion; win_en  in  CHANNEL_COUNT*WINDOW_COUNT  window enable; win_on, win_off  in  CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH  window edges, index ch*WINDOW_COUNT+w.
REQ-010 SHALL have ports: tdd_out  out  CHANNEL_COUNT  channel outputs; cstate  out  2  FSM state; counter  out  REGISTER_WIDTH; frame_index  out  BURST_COUNT_WIDTH; end_of_frame  out  1  pulse; cfg_err  out  1  sticky.

Function
REQ-011 SHALL implement FSM states IDLE, ARMED, WAITING, RUNNING.
REQ-012 SHALL go IDLE->ARMED when enable=1; any state->IDLE within one cycle of enable=0, clearing counter, frame_index, and all windows.
REQ-013 SHALL on sync in ARMED capture burst_count, startup_delay, frame_length, ch_pol, win_en, win_on, win_off into shadow registers; live inputs SHALL NOT affect the burst afterwards, except ch_en, which acts live.
REQ-014 SHALL on capture enter WAITING with counter=0 if startup_delay!=0, else RUNNING with counter=0.
REQ-015 SHALL in WAITING increment counter; at counter==startup_delay-1 enter RUNNING with counter=0 next cycle.
REQ-016 SHALL in RUNNING increment counter; at counter==frame_length-1 pulse end_of_frame for one cycle, wrap counter to 0, increment frame_index.
REQ-017 SHALL at end of frame with burst_count!=0 and frame_index==burst_count-1 return to ARMED with frame_index=0; burst_count=0 SHALL repeat forever.
REQ-018 SHALL, if frame_length<2 at sync, ignore the trigger, stay ARMED, set cfg_err; cfg_err SHALL clear only on reset or enable=0.
REQ-019 SHALL with sync_rst=1 treat sync in WAITING/RUNNING as a new capture per REQ-013/014 with frame_index=0; with sync_rst=0 ignore it.
REQ-020 SHALL per window set active on cycle after RUNNING counter==win_on, clear on cycle after counter==win_off; win_on==win_off SHALL never assert; off edge wins.
REQ-021 SHALL force all windows inactive on the cycle after end_of_frame unless win_on==0 re-asserts it, and whenever not RUNNING.
REQ-022 SHALL drive tdd_out[c] = shadow ch_pol[c] XOR (ch_en[c] AND OR of window actives), registered; latency from counter match to tdd_out is 1 cycle.
REQ-023 SHALL drive tdd_out[c]=ch_pol[c] (live) in IDLE/ARMED; windows with win_on >= frame_length SHALL never assert.

Reset
REQ-024 SHALL on reset: cstate=IDLE, counter=0, frame_index=0, end_of_frame=0, cfg_err=0, windows inactive, shadows=0, tdd_out=DEFAULT_POLARITY.
REQ-025 SHALL honour reset mid-burst, next cycle values as REQ-024 regardless of enable or sync.

Structure
REQ-026 SHALL place state_t enum (IDLE=0, ARMED=1, WAITING=2, RUNNING=3) in package tdd_seq_gen_pkg.
REQ-027 SHALL instantiate sub-module tdd_seq_gen_channel per channel, holding WINDOW_COUNT window trackers and the output register.

Verification
REQ-028 Burst: frame_length=10, startup_delay=3, burst_count=2, win0 on=2 off=5 -> sync at t0, first counter=0 in RUNNING at t0+4, tdd_out high counter 3..5 in two frames, then ARMED.
REQ-029 Multi-window: win0 2..4, win1 6..8, ch_pol=1 -> two low pulses of 2 cycles per frame; win_on==win_off window stays idle.
REQ-030 Shadowing: change frame_length 10->20 mid-burst -> frame length stays 10 until next ARMED capture.
REQ-031 Retrigger: sync_rst=1, sync at counter=6 frame 1 -> frame_index=0, restart WAITING; sync_rst=0 -> no change.
REQ-032 Errors/abort: frame_length=1 sync -> cfg_err=1, ARMED; enable=0 mid-window -> IDLE, tdd_out=ch_pol next cycle.
REQ-033 Reset mid-RUNNING with burst_count=0 -> all outputs per REQ-024 next cycle.
